alu_expr_sched: RTL and testbench



---
 rtl/alu_expr_sched.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_expr_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_expr_sched.sv
// alu_expr_sched
//   Sequencer for the shared ALU datapath. It takes an infix token stream
//   (operands, operators, '=', clear), resolves precedence with small
//   operand/operator stacks, issues one ALU operation at a time through
//   registered alu_a/alu_b/alu_cs, and presents the final value on a
//   valid/ready result port.
//
//   Configuration macro: ALU_EXPR_SCHED_PREC_EN
//     defined   : precedence AND/OR > ADD/SUB > SLT, left-associative,
//                 operand stack depth 4, operator stack depth 3.
//     undefined : strict left-to-right evaluation, operand stack depth 2,
//                 operator stack depth 1.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     tok_valid/tok_ready token handshake
//     tok_kind            00 operand, 01 operator, 10 equals, 11 clear
//     tok_data            operand value, or operator code in [OPW-1:0]
//     alu_a/alu_b/alu_cs  registered ALU operands and operation select
//     alu_s               combinational ALU result
//     res_valid/res_ready result handshake, res_data final value
//     busy                high while reducing / finishing
//     err                 sticky syntax error, cleared by a clear token
module alu_expr_sched #(
    parameter int unsigned W   = 11,
    parameter int unsigned OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tok_valid,
    output logic           tok_ready,
    input  logic [1:0]     tok_kind,
    input  logic [W-1:0]   tok_data,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_cs,
    input  logic [W-1:0]   alu_s,
    output logic           res_valid,
    output logic [W-1:0]   res_data,
    input  logic           res_ready,
    output logic           busy,
    output logic           err
);

`ifdef ALU_EXPR_SCHED_PREC_EN
    localparam int unsigned OPND_D = 4;
    localparam int unsigned OPR_D  = 3;
    localparam logic [OPW-1:0] OP_AND = OPW'(0);
    localparam logic [OPW-1:0] OP_OR  = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(3);
`else
    localparam int unsigned OPND_D = 2;
    localparam int unsigned OPR_D  = 1;
`endif
    localparam logic [OPW-1:0] OP_SLT = OPW'(4);

    // Index widths; storage is rounded up to a power of two so every
    // index value addresses a real entry.
    localparam int unsigned DIW = (OPND_D > 1) ? $clog2(OPND_D) : 1;
    localparam int unsigned RIW = (OPR_D > 1) ? $clog2(OPR_D) : 1;

    localparam logic [1:0] K_OPND = 2'b00;
    localparam logic [1:0] K_OP   = 2'b01;
    localparam logic [1:0] K_EQ   = 2'b10;
    localparam logic [1:0] K_CLR  = 2'b11;

    typedef enum logic [2:0] {
        S_EXP_OPND,
        S_EXP_OP,
        S_REDUCE,
        S_CAPTURE,
        S_FINAL,
        S_DONE,
        S_ERROR
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_opnd [0:(2**DIW)-1];
    logic [OPW-1:0] r_op   [0:(2**RIW)-1];
    logic [DIW:0]   r_dcnt;
    logic [RIW:0]   r_rcnt;
    logic [OPW-1:0] r_pend_op;
    logic           r_final;
    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic [OPW-1:0] r_alu_cs;
    logic           r_res_valid;
    logic [W-1:0]   r_res_data;

    logic [DIW-1:0] w_dtop_i;
    logic [DIW-1:0] w_dsec_i;
    logic [RIW-1:0] w_rtop_i;
    logic           w_fire;
    logic           w_legal;
    logic           w_need_red;

`ifdef ALU_EXPR_SCHED_PREC_EN
    function automatic logic [1:0] f_prec(input logic [OPW-1:0] op);
        case (op)
            OP_AND, OP_OR:  f_prec = 2'd2;
            OP_ADD, OP_SUB: f_prec = 2'd1;
            default:        f_prec = 2'd0;
        endcase
    endfunction
`endif

    assign w_dtop_i = r_dcnt[DIW-1:0] - DIW'(1);
    assign w_dsec_i = r_dcnt[DIW-1:0] - DIW'(2);
    assign w_rtop_i = r_rcnt[RIW-1:0] - RIW'(1);
    assign w_fire   = tok_valid && tok_ready;
    assign w_legal  = (tok_data[OPW-1:0] <= OP_SLT);

    always_comb begin
        w_need_red = 1'b0;
        if (r_rcnt != '0) begin
`ifdef ALU_EXPR_SCHED_PREC_EN
            w_need_red = r_final || (f_prec(r_op[w_rtop_i]) >= f_prec(r_pend_op));
`else
            w_need_red = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EXP_OPND;
            r_dcnt      <= '0;
            r_rcnt      <= '0;
            r_pend_op   <= '0;
            r_final     <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_cs    <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            for (int unsigned i = 0; i < 2**DIW; i++) r_opnd[i] <= '0;
            for (int unsigned i = 0; i < 2**RIW; i++) r_op[i] <= '0;
        end else begin
            case (r_state)
                S_EXP_OPND: begin
                    if (w_fire) begin
                        case (tok_kind)
                            K_OPND: begin
                                r_opnd[r_dcnt[DIW-1:0]] <= tok_data;
                                r_dcnt  <= r_dcnt + (DIW+1)'(1);
                                r_state <= S_EXP_OP;
                            end
                            K_CLR: begin
                                r_dcnt  <= '0;
                                r_rcnt  <= '0;
                                r_state <= S_EXP_OPND;
                            end
                            default: r_state <= S_ERROR;
                        endcase
                    end
                end
                S_EXP_OP: begin
                    if (w_fire) begin
                        case (tok_kind)
                            K_OPND: r_state <= S_ERROR;
                            K_OP: begin
                                if (w_legal) begin
                                    r_pend_op <= tok_data[OPW-1:0];
                                    r_final   <= 1'b0;
                                    r_state   <= S_REDUCE;
                                end else begin
                                    r_state <= S_ERROR;
                                end
                            end
                            K_EQ: begin
                                r_final <= 1'b1;
                                r_state <= S_REDUCE;
                            end
                            default: begin
                                r_dcnt  <= '0;
                                r_rcnt  <= '0;
                                r_state <= S_EXP_OPND;
                            end
                        endcase
                    end
                end
                S_REDUCE: begin
                    if (w_need_red) begin
                        r_alu_a  <= r_opnd[w_dsec_i];
                        r_alu_b  <= r_opnd[w_dtop_i];
                        r_alu_cs <= r_op[w_rtop_i];
                        r_state  <= S_CAPTURE;
                    end else if (!r_final) begin
                        r_op[r_rcnt[RIW-1:0]] <= r_pend_op;
                        r_rcnt  <= r_rcnt + (RIW+1)'(1);
                        r_state <= S_EXP_OPND;
                    end else begin
                        // Result is loaded on entry to FINAL so it is already
                        // visible (and can hand off) during the FINAL cycle.
                        r_res_data  <= r_opnd[w_dtop_i];
                        r_res_valid <= 1'b1;
                        r_state     <= S_FINAL;
                    end
                end
                S_CAPTURE: begin
                    r_opnd[w_dsec_i] <= alu_s;
                    r_dcnt  <= r_dcnt - (DIW+1)'(1);
                    r_rcnt  <= r_rcnt - (RIW+1)'(1);
                    r_state <= S_REDUCE;
                end
                S_FINAL, S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_dcnt      <= '0;
                        r_rcnt      <= '0;
                        r_state     <= S_EXP_OPND;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_ERROR: begin
                    if (w_fire && (tok_kind == K_CLR)) begin
                        r_dcnt  <= '0;
                        r_rcnt  <= '0;
                        r_state <= S_EXP_OPND;
                    end
                end
                default: r_state <= S_EXP_OPND;
            endcase
        end
    end

    assign tok_ready = (r_state == S_EXP_OPND) || (r_state == S_EXP_OP) ||
                       (r_state == S_ERROR);
    assign busy      = (r_state == S_REDUCE) || (r_state == S_CAPTURE) ||
                       (r_state == S_FINAL);
    assign err       = (r_state == S_ERROR);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_cs    = r_alu_cs;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

endmodule

// File: tb/tb_alu_expr_sched.sv
`timescale 1ns/1ps
module tb_alu_expr_sched;
    localparam int unsigned W   = 11;
    localparam int unsigned OPW = 3;
`ifdef ALU_EXPR_SCHED_PREC_EN
    localparam bit PREC = 1'b1;
`else
    localparam bit PREC = 1'b0;
`endif
    localparam logic [1:0] K_OPND = 2'b00;
    localparam logic [1:0] K_OP   = 2'b01;
    localparam logic [1:0] K_EQ   = 2'b10;
    localparam logic [1:0] K_CLR  = 2'b11;
    localparam logic [2:0] O_AND = 3'd0;
    localparam logic [2:0] O_OR  = 3'd1;
    localparam logic [2:0] O_ADD = 3'd2;
    localparam logic [2:0] O_SUB = 3'd3;
    localparam logic [2:0] O_SLT = 3'd4;

    logic           clk = 1'b0;
    logic           rst;
    logic           tok_valid;
    logic           tok_ready;
    logic [1:0]     tok_kind;
    logic [W-1:0]   tok_data;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [OPW-1:0] alu_cs;
    logic [W-1:0]   alu_s;
    logic           res_valid;
    logic [W-1:0]   res_data;
    logic           res_ready;
    logic           busy;
    logic           err;

    int n_cmp = 0;
    int n_bad = 0;

    alu_expr_sched #(.W(W), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_kind(tok_kind), .tok_data(tok_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cs(alu_cs), .alu_s(alu_s),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] cs);
        case (cs)
            O_AND:   return a & b;
            O_OR:    return a | b;
            O_ADD:   return a + b;
            O_SUB:   return a - b;
            O_SLT:   return (a < b) ? W'(1) : W'(0);
            default: return '0;
        endcase
    endfunction

    assign alu_s = alu_f(alu_a, alu_b, alu_cs);

    function automatic int prec(input logic [2:0] op);
        if (op == O_AND || op == O_OR) return 2;
        if (op == O_ADD || op == O_SUB) return 1;
        return 0;
    endfunction

    // Reference: collapse highest-precedence operators first, scanning left
    // to right (left-associative); without precedence, a plain left fold.
    function automatic logic [W-1:0] model(input int n, input logic [3:0][2:0] ops,
                                           input logic [4:0][W-1:0] v);
        logic [W-1:0] vq[$];
        logic [2:0]   oq[$];
        int           i;
        for (int k = 0; k <= n; k++) vq.push_back(v[k]);
        for (int k = 0; k < n; k++) oq.push_back(ops[k]);
        if (PREC) begin
            for (int lvl = 2; lvl >= 0; lvl--) begin
                i = 0;
                while (i < oq.size()) begin
                    if (prec(oq[i]) == lvl) begin
                        vq[i] = alu_f(vq[i], vq[i+1], oq[i]);
                        vq.delete(i+1);
                        oq.delete(i);
                    end else begin
                        i++;
                    end
                end
            end
        end else begin
            while (oq.size() > 0) begin
                vq[0] = alu_f(vq[0], vq[1], oq[0]);
                vq.delete(1);
                oq.delete(0);
            end
        end
        return vq[0];
    endfunction

    // ALU issue log: every change of the registered ALU inputs.
    logic [2*W+OPW-1:0] iss_q[$];
    logic [2*W+OPW-1:0] iss_prev = '0;
    always @(negedge clk) begin
        if ({alu_a, alu_b, alu_cs} != iss_prev) begin
            iss_q.push_back({alu_a, alu_b, alu_cs});
            iss_prev = {alu_a, alu_b, alu_cs};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] k, input logic [W-1:0] d);
        int n;
        n = 0;
        while (!tok_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!tok_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: tok_ready stayed 0 for %0d cycles, required 1", n);
        end
        tok_valid = 1'b1;
        tok_kind  = k;
        tok_data  = d;
        @(posedge clk); #1;
        tok_valid = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 1;
        while (!tok_ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_res(output int lat);
        lat = 1;
        while (!res_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!res_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL res_timeout: res_valid stayed 0 for %0d cycles, required 1", lat);
        end
    endtask

    task automatic take(input int dly);
        repeat (dly) begin @(posedge clk); #1; end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic run_expr(input int n, input logic [3:0][2:0] ops,
                            input logic [4:0][W-1:0] v, input int dly,
                            output logic [W-1:0] res, output int lat);
        for (int k = 0; k < n; k++) begin
            send(K_OPND, v[k]);
            send(K_OP, W'(ops[k]));
        end
        send(K_OPND, v[n]);
        send(K_EQ, '0);
        wait_res(lat);
        res = res_data;
        take(dly);
    endtask

    typedef struct packed {
        logic [3:0]          n;
        logic [3:0][2:0]     ops;
        logic [4:0][W-1:0]   v;
        logic [W-1:0]        res;
        logic [4:0]          lat;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [2:0] o0, input logic [2:0] o1,
                                input logic [2:0] o2, input int v0, input int v1,
                                input int v2, input int v3, input int res, input int lat);
        vec_t t;
        t.n   = 4'(n);
        t.ops = {3'd0, o2, o1, o0};
        t.v   = {W'(0), W'(v3), W'(v2), W'(v1), W'(v0)};
        t.res = W'(res);
        t.lat = 5'(lat);
        return t;
    endfunction

    vec_t               tv[7];
    logic [W-1:0]       r;
    int                 lat;
    int                 seen;
    int                 n_ops;
    logic [3:0][2:0]    rops;
    logic [4:0][W-1:0]  rv;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = mk(2, O_ADD, O_AND, O_AND, 4, 3, 1, 0, PREC ? 5 : 1, PREC ? 6 : 4);
        tv[1] = mk(2, O_SUB, O_SUB, O_AND, 5, 3, 1, 0, 1, 4);
        tv[2] = mk(2, O_SLT, O_ADD, O_AND, 2, 1, 5, 0, PREC ? 1 : 5, PREC ? 6 : 4);
        tv[3] = mk(0, O_AND, O_AND, O_AND, 7, 0, 0, 0, 7, 2);
        tv[4] = mk(1, O_OR,  O_AND, O_AND, 9, 6, 0, 0, 15, 4);
        tv[5] = mk(3, O_SLT, O_ADD, O_AND, 1, 2, 3, 4, PREC ? 1 : 4, PREC ? 8 : 4);
        tv[6] = mk(1, O_SUB, O_AND, O_AND, 0, 1, 0, 0, 2047, 4);

        rst = 1'b1; tok_valid = 1'b0; tok_kind = '0; tok_data = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_tok_ready", tok_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_cs", alu_cs, 0);

        for (int i = 0; i < 7; i++) begin
            run_expr(int'(tv[i].n), tv[i].ops, tv[i].v, i % 3, r, lat);
            chk($sformatf("vec%0d_res", i), r, tv[i].res);
            chk($sformatf("vec%0d_lat", i), lat, tv[i].lat);
            chk($sformatf("vec%0d_ready_after", i), tok_ready, 1);
        end

        // 5 - 3 - 1: left-associative, two SUB issues, operator latencies.
        iss_q.delete();
        send(K_OPND, 5);
        send(K_OP, W'(O_SUB));
        wait_ready(lat);
        chk("sub1_ready_lat", lat, 2);
        send(K_OPND, 3);
        send(K_OP, W'(O_SUB));
        wait_ready(lat);
        chk("sub2_ready_lat", lat, 4);
        send(K_OPND, 1);
        send(K_EQ, '0);
        wait_res(lat);
        chk("subsub_res", res_data, 1);
        take(0);
        chk("subsub_issues", iss_q.size(), 2);
        if (iss_q.size() == 2) begin
            chk("subsub_issue0", iss_q[0], {W'(5), W'(3), O_SUB});
            chk("subsub_issue1", iss_q[1], {W'(2), W'(1), O_SUB});
        end

        // 2 SLT 1 ADD 5: issue order and '=' latency.
        iss_q.delete();
        send(K_OPND, 2);
        send(K_OP, W'(O_SLT));
        send(K_OPND, 1);
        send(K_OP, W'(O_ADD));
        send(K_OPND, 5);
        send(K_EQ, '0);
        wait_res(lat);
        chk("slt_lat", lat, PREC ? 6 : 4);
        chk("slt_res", res_data, PREC ? 1 : 5);
        take(0);
        chk("slt_issues", iss_q.size(), 2);
        if (iss_q.size() == 2) begin
            chk("slt_cs0", iss_q[0][OPW-1:0], PREC ? O_ADD : O_SLT);
            chk("slt_cs1", iss_q[1][OPW-1:0], PREC ? O_SLT : O_ADD);
        end

        // Result held while res_ready stays low.
        send(K_OPND, 4);
        send(K_OP, W'(O_ADD));
        send(K_OPND, 3);
        send(K_EQ, '0);
        wait_res(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_valid", i), res_valid, 1);
            chk($sformatf("hold%0d_data", i), res_data, 7);
            chk($sformatf("hold%0d_tok_ready", i), tok_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("hold_release_tok_ready", tok_ready, 1);
        chk("hold_release_valid", res_valid, 0);

        // Syntax error, ignored tokens, clear.
        send(K_OP, W'(O_ADD));
        chk("err_set", err, 1);
        chk("err_tok_ready", tok_ready, 1);
        send(K_OPND, 3);
        send(K_EQ, '0);
        @(posedge clk); #1;
        chk("err_sticky", err, 1);
        chk("err_no_busy", busy, 0);
        chk("err_no_result", res_valid, 0);
        send(K_CLR, '0);
        chk("err_cleared", err, 0);
        send(K_OPND, 7);
        send(K_EQ, '0);
        wait_res(lat);
        chk("after_clear_res", res_data, 7);
        take(1);

        // Illegal operator code.
        send(K_OPND, 3);
        send(K_OP, W'(5));
        chk("illegal_op_err", err, 1);
        send(K_CLR, '0);
        chk("illegal_op_clear", err, 0);

        // Reset during CAPTURE aborts with no result.
        send(K_OPND, 9);
        send(K_OP, W'(O_OR));
        send(K_OPND, 6);
        send(K_EQ, '0);
        @(posedge clk); #1;
        chk("cap_busy", busy, 1);
        chk("cap_alu", {alu_a, alu_b, alu_cs}, {W'(9), W'(6), O_OR});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_tok_ready", tok_ready, 1);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_data", res_data, 0);
        chk("abort_err", err, 0);
        chk("abort_busy", busy, 0);
        chk("abort_alu", {alu_a, alu_b, alu_cs}, 0);
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1;
        end
        chk("abort_no_result", seen, 0);
        run_expr(1, {3'd0, 3'd0, 3'd0, O_OR}, {W'(0), W'(0), W'(0), W'(6), W'(9)}, 0, r, lat);
        chk("rerun_res", r, 15);

        // Random expressions against the reference model.
        for (int t = 0; t < 40; t++) begin
            n_ops = $urandom_range(0, PREC ? 3 : 4);
            for (int k = 0; k < 4; k++) rops[k] = 3'($urandom_range(0, 4));
            for (int k = 0; k < 5; k++) rv[k] = (t % 2 == 0) ? W'($urandom) : W'($urandom_range(0, 7));
            run_expr(n_ops, rops, rv, $urandom_range(0, 3), r, lat);
            chk($sformatf("rand%0d_res", t), r, model(n_ops, rops, rv));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
